// File: rtl/h_csr_encoder.sv
// h_csr_encoder: dense-row to CSR-style producer for the H sparse-feature BRAMs.
// Consumes one dense feature element per cycle, drops zeros, and writes packed
// {col_idx, value} entries to H_data plus one {row_length, num_of_nodes,
// source_node_flag} record per row to H_node_info.
//
// Ports:
//   clk, rst_n              clock / asynchronous active-low reset
//   start_i, total_rows_i   start pulse and row count (sampled in IDLE only)
//   feat_valid_i/ready_o    element handshake, feat_data_i element value
//   row_num_nodes_i         per-row num_of_nodes, sampled with column 0
//   row_src_flag_i          per-row source_node_flag, sampled with column 0
//   H_data_BRAM_*           data entry write port
//   H_node_info_BRAM_*      node-info record write port
//   nnz_count_o             entries written, valid with done_o
//   overflow_o              sticky capacity / row_length saturation flag
//   done_o                  one-cycle completion pulse
//
// Address widths use clog2(DEPTH + 1) so an address can hold the value DEPTH
// (the "full" marker) even for power-of-two depths; for the default depths
// this equals clog2(DEPTH).
module h_csr_encoder #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned NUM_FEATURES    = 1433,
   parameter int unsigned COL_IDX_WIDTH   = 11,
   parameter int unsigned ROW_LEN_WIDTH   = 11,
   parameter int unsigned NUM_NODE_WIDTH  = 7,
   parameter int unsigned H_DATA_DEPTH    = 242101,
   parameter int unsigned NODE_INFO_DEPTH = 13264,
   localparam int unsigned H_DATA_ADDR_W    = $clog2(H_DATA_DEPTH + 1),
   localparam int unsigned NODE_INFO_ADDR_W = $clog2(NODE_INFO_DEPTH + 1),
   localparam int unsigned H_DATA_WIDTH     = COL_IDX_WIDTH + DATA_WIDTH,
   localparam int unsigned NODE_INFO_WIDTH  = ROW_LEN_WIDTH + NUM_NODE_WIDTH + 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start_i,
   input  logic [NODE_INFO_ADDR_W-1:0] total_rows_i,
   input  logic                        feat_valid_i,
   output logic                        feat_ready_o,
   input  logic [DATA_WIDTH-1:0]       feat_data_i,
   input  logic [NUM_NODE_WIDTH-1:0]   row_num_nodes_i,
   input  logic                        row_src_flag_i,
   output logic [H_DATA_WIDTH-1:0]     H_data_BRAM_din,
   output logic                        H_data_BRAM_ena,
   output logic [H_DATA_ADDR_W-1:0]    H_data_BRAM_addra,
   output logic [NODE_INFO_WIDTH-1:0]  H_node_info_BRAM_din,
   output logic                        H_node_info_BRAM_ena,
   output logic [NODE_INFO_ADDR_W-1:0] H_node_info_BRAM_addra,
   output logic [H_DATA_ADDR_W-1:0]    nnz_count_o,
   output logic                        overflow_o,
   output logic                        done_o
);

   typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_t;

   state_t                        state, state_d;
   logic [COL_IDX_WIDTH-1:0]      col;
   logic [ROW_LEN_WIDTH-1:0]      row_len;
   logic [NODE_INFO_ADDR_W-1:0]   rows_left;
   logic [NUM_NODE_WIDTH-1:0]     nodes_q;
   logic                          flag_q;
   logic [H_DATA_ADDR_W-1:0]      data_addr;
   logic [NODE_INFO_ADDR_W-1:0]   node_addr;

   logic                          start_c;
   logic                          accept_c;
   logic                          nz_c;
   logic                          first_col_c;
   logic                          last_col_c;
   logic                          last_row_c;
   logic [ROW_LEN_WIDTH-1:0]      base_len_c;
   logic                          len_sat_c;
   logic [ROW_LEN_WIDTH-1:0]      len_next_c;
   logic                          filler_c;
   logic [ROW_LEN_WIDTH-1:0]      len_final_c;
   logic                          need_data_c;
   logic                          need_node_c;
   logic                          data_full_c;
   logic                          node_full_c;
   logic                          ovf_set_c;
   logic [NUM_NODE_WIDTH-1:0]     nodes_cur_c;
   logic                          flag_cur_c;
   logic [H_DATA_WIDTH-1:0]       data_din_c;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state and per-element write decisions
   always_comb begin
      state_d     = state;
      start_c     = 1'b0;
      accept_c    = 1'b0;
      nz_c        = (feat_data_i != '0);
      first_col_c = (col == '0);
      last_col_c  = (col == COL_IDX_WIDTH'(NUM_FEATURES - 1));
      last_row_c  = (rows_left == NODE_INFO_ADDR_W'(1));

      case (state)
         IDLE: begin
            start_c = start_i;
            if (start_i) begin
               state_d = (total_rows_i != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            accept_c = feat_valid_i;
            if (feat_valid_i && last_col_c && last_row_c) begin
               state_d = LAST;
            end
         end
         LAST:    state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Row length restarts at column 0 and saturates at all-ones
      base_len_c  = first_col_c ? '0 : row_len;
      len_sat_c   = nz_c && (&base_len_c);
      len_next_c  = (nz_c && !len_sat_c) ? base_len_c + ROW_LEN_WIDTH'(1) : base_len_c;
      // An all-zero row still needs one {0,0} entry so row_length >= 1
      filler_c    = last_col_c && (len_next_c == '0);
      len_final_c = filler_c ? ROW_LEN_WIDTH'(1) : len_next_c;

      need_data_c = accept_c && (nz_c || filler_c);
      need_node_c = accept_c && last_col_c;
      data_full_c = (data_addr == H_DATA_ADDR_W'(H_DATA_DEPTH));
      node_full_c = (node_addr == NODE_INFO_ADDR_W'(NODE_INFO_DEPTH));
      ovf_set_c   = (need_data_c && data_full_c) || (need_node_c && node_full_c)
                    || (accept_c && len_sat_c);

      // Single-column rows must use the live sideband, not the stale latch
      nodes_cur_c = first_col_c ? row_num_nodes_i : nodes_q;
      flag_cur_c  = first_col_c ? row_src_flag_i  : flag_q;
      data_din_c  = nz_c ? {col, feat_data_i} : '0;
   end

   // Datapath, counters and registered BRAM write ports
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col                    <= '0;
         row_len                <= '0;
         rows_left              <= '0;
         nodes_q                <= '0;
         flag_q                 <= 1'b0;
         data_addr              <= '0;
         node_addr              <= '0;
         feat_ready_o           <= 1'b0;
         H_data_BRAM_din        <= '0;
         H_data_BRAM_ena        <= 1'b0;
         H_data_BRAM_addra      <= '0;
         H_node_info_BRAM_din   <= '0;
         H_node_info_BRAM_ena   <= 1'b0;
         H_node_info_BRAM_addra <= '0;
         nnz_count_o            <= '0;
         overflow_o             <= 1'b0;
         done_o                 <= 1'b0;
      end else begin
         H_data_BRAM_ena      <= 1'b0;
         H_node_info_BRAM_ena <= 1'b0;
         feat_ready_o         <= (state_d == RUN);
         done_o               <= (state_d == DONE);

         if (start_c) begin
            col         <= '0;
            row_len     <= '0;
            rows_left   <= total_rows_i;
            data_addr   <= '0;
            node_addr   <= '0;
            nnz_count_o <= '0;
            overflow_o  <= 1'b0;
         end else begin
            if (ovf_set_c) begin
               overflow_o <= 1'b1;
            end

            if (accept_c) begin
               row_len <= len_next_c;
               col     <= last_col_c ? '0 : col + COL_IDX_WIDTH'(1);
               if (first_col_c) begin
                  nodes_q <= row_num_nodes_i;
                  flag_q  <= row_src_flag_i;
               end
               if (last_col_c) begin
                  rows_left <= rows_left - NODE_INFO_ADDR_W'(1);
               end
            end

            // Full data port: write dropped, address held
            if (need_data_c && !data_full_c) begin
               H_data_BRAM_din   <= data_din_c;
               H_data_BRAM_ena   <= 1'b1;
               H_data_BRAM_addra <= data_addr;
               data_addr         <= data_addr + H_DATA_ADDR_W'(1);
            end

            if (need_node_c && !node_full_c) begin
               H_node_info_BRAM_din   <= {len_final_c, nodes_cur_c, flag_cur_c};
               H_node_info_BRAM_ena   <= 1'b1;
               H_node_info_BRAM_addra <= node_addr;
               node_addr              <= node_addr + NODE_INFO_ADDR_W'(1);
            end

            // Last writes retired on entry to LAST; data_addr is final here
            if (state == LAST) begin
               nnz_count_o <= data_addr;
            end
         end
      end
   end

endmodule
